// File: rtl/ctrl_pkg.sv
// Shared encodings for the pipelined MIPS control unit: opcodes, function
// codes, control-word field values, field bit offsets and the packed layout.
package ctrl_pkg;

    localparam int CTRL_W = 24;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;

    // Field encodings
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b110;

    localparam logic [1:0] SH_SRLV = 2'b00;
    localparam logic [1:0] SH_SRAV = 2'b01;
    localparam logic [1:0] SH_SLLV = 2'b10;

    localparam logic [1:0] BJ_SEQ    = 2'b00;
    localparam logic [1:0] BJ_JUMP   = 2'b01;
    localparam logic [1:0] BJ_BRANCH = 2'b10;

    localparam logic [1:0] PC_JTARGET = 2'b01;
    localparam logic [1:0] PC_REG     = 2'b10;

    localparam logic [2:0] CMP_BEQ  = 3'b000;
    localparam logic [2:0] CMP_BNE  = 3'b001;
    localparam logic [2:0] CMP_BLEZ = 3'b010;
    localparam logic [2:0] CMP_BGTZ = 3'b011;

    localparam logic [2:0] WSRC_ALU = 3'b000;
    localparam logic [2:0] WSRC_MEM = 3'b001;

    localparam logic [1:0] RDST_RT = 2'b00;
    localparam logic [1:0] RDST_RD = 2'b01;

    // Bit offsets of each field inside the control word
    localparam int OFF_UNSIG       = 0;
    localparam int OFF_COMPOP      = 1;
    localparam int OFF_SELPCTYPE   = 4;
    localparam int OFF_SELBRJUMPZ  = 6;
    localparam int OFF_WRITEMEM    = 8;
    localparam int OFF_READMEM     = 9;
    localparam int OFF_SHIFTOP     = 10;
    localparam int OFF_ALUOP       = 12;
    localparam int OFF_SELALUSHIFT = 15;
    localparam int OFF_SELIMREGB   = 16;
    localparam int OFF_WRITEOV     = 17;
    localparam int OFF_WRITEREG    = 18;
    localparam int OFF_SELREGDEST  = 19;
    localparam int OFF_SELWSOURCE  = 21;

    // Packed view of the control word, MSB first
    typedef struct packed {
        logic [2:0] selwsource;
        logic [1:0] selregdest;
        logic       writereg;
        logic       writeov;
        logic       selimregb;
        logic       selalushift;
        logic [2:0] aluop;
        logic [1:0] shiftop;
        logic       readmem;
        logic       writemem;
        logic [1:0] selbrjumpz;
        logic [1:0] selpctype;
        logic [2:0] compop;
        logic       unsig;
    } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// Combinational decoder: turns op/fn and the register fields of the
// instruction sitting in ID into a complete control word, its write-back
// register, an illegal flag and which source registers it reads.
module control_decode
    import ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [5:0]        op,
    input  logic [5:0]        fn,
    input  logic [REG_AW-1:0] rt,
    input  logic [REG_AW-1:0] rd,
    output logic [CTRL_W-1:0] ctrl,
    output logic [REG_AW-1:0] dest,
    output logic              illegal,
    output logic              uses_rs,
    output logic              uses_rt
);

    ctrl_t c;
    logic  r_write;

    // Decode table; anything not recognised leaves the word all-zero and flags illegal
    always_comb begin
        c       = '0;
        r_write = 1'b0;
        illegal = 1'b0;
        dest    = '0;
        uses_rs = (op != OP_J);
        uses_rt = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
        case (op)
            OP_RTYPE: begin
                r_write = 1'b1;
                case (fn)
                    FN_ADD:  begin c.aluop = ALU_ADD; c.writeov = 1'b1; end
                    FN_ADDU: begin c.aluop = ALU_ADD; c.unsig = 1'b1; end
                    FN_SUB:  begin c.aluop = ALU_SUB; c.writeov = 1'b1; end
                    FN_SUBU: begin c.aluop = ALU_SUB; c.unsig = 1'b1; end
                    FN_AND:  c.aluop = ALU_AND;
                    FN_OR:   c.aluop = ALU_OR;
                    FN_XOR:  c.aluop = ALU_XOR;
                    FN_NOR:  c.aluop = ALU_NOR;
                    FN_SLLV: begin c.selalushift = 1'b1; c.shiftop = SH_SLLV; end
                    FN_SRLV: begin c.selalushift = 1'b1; c.shiftop = SH_SRLV; end
                    FN_SRAV: begin c.selalushift = 1'b1; c.shiftop = SH_SRAV; end
                    FN_JR: begin
                        r_write      = 1'b0;
                        c.selbrjumpz = BJ_JUMP;
                        c.selpctype  = PC_REG;
                    end
                    default: begin
                        r_write = 1'b0;
                        illegal = 1'b1;
                    end
                endcase
                if (r_write) begin
                    c.writereg   = 1'b1;
                    c.selregdest = RDST_RD;
                end
            end
            OP_J: begin
                c.selbrjumpz = BJ_JUMP;
                c.selpctype  = PC_JTARGET;
            end
            OP_BEQ:  begin c.selbrjumpz = BJ_BRANCH; c.compop = CMP_BEQ;  end
            OP_BNE:  begin c.selbrjumpz = BJ_BRANCH; c.compop = CMP_BNE;  end
            OP_BLEZ: begin c.selbrjumpz = BJ_BRANCH; c.compop = CMP_BLEZ; end
            OP_BGTZ: begin c.selbrjumpz = BJ_BRANCH; c.compop = CMP_BGTZ; end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: begin
                c.selimregb  = 1'b1;
                c.writereg   = 1'b1;
                c.selregdest = RDST_RT;
                c.writeov    = (op == OP_ADDI);
                c.unsig      = (op != OP_ADDI);
                case (op)
                    OP_ANDI: c.aluop = ALU_AND;
                    OP_ORI:  c.aluop = ALU_OR;
                    OP_XORI: c.aluop = ALU_XOR;
                    default: c.aluop = ALU_ADD;
                endcase
            end
            OP_LW: begin
                c.selwsource = WSRC_MEM;
                c.selregdest = RDST_RT;
                c.writereg   = 1'b1;
                c.selimregb  = 1'b1;
                c.aluop      = ALU_ADD;
                c.readmem    = 1'b1;
            end
            OP_SW: begin
                c.selimregb = 1'b1;
                c.aluop     = ALU_ADD;
                c.writemem  = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        if (c.writereg) begin
            dest = (c.selregdest == RDST_RD) ? rd : rt;
        end
        ctrl = c;
    end

endmodule

// File: rtl/control_pipe.sv
// Pipelined control unit: holds the fetched instruction in ID, decodes it,
// and carries the control word and destination register through EX, MEM
// and WB, with load-use interlock, branch flush and illegal flagging.
module control_pipe
    import ctrl_pkg::*;
#(
    parameter int REG_AW         = 5,
    parameter bit LOAD_USE_STALL = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [31:0]       instr,
    output logic              in_ready,
    input  logic              flush,
    output logic              ex_valid,
    output logic              mem_valid,
    output logic              wb_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CTRL_W-1:0] mem_ctrl,
    output logic [CTRL_W-1:0] wb_ctrl,
    output logic [REG_AW-1:0] ex_dest,
    output logic [REG_AW-1:0] mem_dest,
    output logic [REG_AW-1:0] wb_dest,
    output logic              illegal
);

    logic              id_valid;
    logic [5:0]        id_op;
    logic [5:0]        id_fn;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic              ex_illegal;

    logic [CTRL_W-1:0] dec_ctrl;
    logic [REG_AW-1:0] dec_dest;
    logic              dec_illegal;
    logic              dec_uses_rs;
    logic              dec_uses_rt;
    logic              stall;
    logic              rs_hit;
    logic              rt_hit;

    // The shift-amount field is never needed by the control path
    logic unused_shamt;
    assign unused_shamt = ^instr[10:6];

    control_decode #(.REG_AW(REG_AW)) u_decode (
        .op      (id_op),
        .fn      (id_fn),
        .rt      (id_rt),
        .rd      (id_rd),
        .ctrl    (dec_ctrl),
        .dest    (dec_dest),
        .illegal (dec_illegal),
        .uses_rs (dec_uses_rs),
        .uses_rt (dec_uses_rt)
    );

    // Load in EX whose result the ID instruction reads; $0 never creates a dependency
    always_comb begin
        rs_hit   = dec_uses_rs && (ex_dest == id_rs);
        rt_hit   = dec_uses_rt && (ex_dest == id_rt);
        stall    = LOAD_USE_STALL && id_valid && ex_valid && ex_ctrl[OFF_READMEM]
                   && (ex_dest != '0) && (rs_hit || rt_hit);
        in_ready = !stall && !flush;
        illegal  = ex_valid && ex_illegal;
    end

    // ID: killed by flush, held by stall, otherwise takes the offered instruction or a bubble
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            id_valid <= 1'b0;
            id_op    <= '0;
            id_fn    <= '0;
            id_rs    <= '0;
            id_rt    <= '0;
            id_rd    <= '0;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (!stall) begin
            id_valid <= in_valid;
            if (in_valid) begin
                id_op <= instr[31:26];
                id_fn <= instr[5:0];
                id_rs <= instr[21 +: REG_AW];
                id_rt <= instr[16 +: REG_AW];
                id_rd <= instr[11 +: REG_AW];
            end
        end
    end

    // EX: a bubble on flush, stall or empty ID, else the decoded ID instruction
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_valid   <= 1'b0;
            ex_ctrl    <= '0;
            ex_dest    <= '0;
            ex_illegal <= 1'b0;
        end else if (flush || stall || !id_valid) begin
            ex_valid   <= 1'b0;
            ex_ctrl    <= '0;
            ex_dest    <= '0;
            ex_illegal <= 1'b0;
        end else begin
            ex_valid   <= 1'b1;
            ex_ctrl    <= dec_ctrl;
            ex_dest    <= dec_dest;
            ex_illegal <= dec_illegal;
        end
    end

    // MEM and WB always advance; a flushed branch still moves from EX into MEM
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_valid <= 1'b0;
            mem_ctrl  <= '0;
            mem_dest  <= '0;
            wb_valid  <= 1'b0;
            wb_ctrl   <= '0;
            wb_dest   <= '0;
        end else begin
            mem_valid <= ex_valid;
            mem_ctrl  <= ex_ctrl;
            mem_dest  <= ex_dest;
            wb_valid  <= mem_valid;
            wb_ctrl   <= mem_ctrl;
            wb_dest   <= mem_dest;
        end
    end

endmodule
